// File: rtl/wb_stream_pkg.sv
// Shared constants and FSM state type for the Wishbone-to-stream fetch engine.
package wb_stream_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INC     = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    READ  = 2'd2,
    DONE  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/wb_stream_fetch_fifo.sv
// First-word-fall-through FIFO, 2**AW entries of DW bits, with a free-slot count.
module wb_stream_fetch_fifo #(
  parameter int DW = 33,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [DW-1:0] push_data_i,
  input  logic          pop_i,
  output logic [DW-1:0] pop_data_o,
  output logic          valid_o,
  output logic [AW:0]   free_o
);

  localparam int          DEPTH   = 2**AW;
  localparam logic [AW:0] DEPTH_C = {1'b1, {AW{1'b0}}};

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  always_comb begin
    do_push  = push_i && (count_q != DEPTH_C);
    do_pop   = pop_i && (count_q != '0);
    wr_ptr_d = wr_ptr_q + {{(AW-1){1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, do_pop};
    count_d  = count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign pop_data_o = mem_q[rd_ptr_q];
  assign valid_o    = (count_q != '0);
  assign free_o     = DEPTH_C - count_q;

endmodule

// File: rtl/wb_stream_fetch.sv
// Wishbone read master streaming a memory buffer out through an FWFT FIFO.
// WB_STREAM_FETCH_BURST_EN selects incrementing bursts instead of classic cycles.
//
// state | meaning
// IDLE  | waiting for enable; latches buffer base and length
// CHECK | waits until the FIFO can absorb the next whole burst
// READ  | bus cycle active, one FIFO push per ack
// DONE  | buffer complete, pulses irq_o
module wb_stream_fetch
  import wb_stream_pkg::*;
#(
  parameter int WB_AW         = 32,
  parameter int WB_DW         = 32,
  parameter int FIFO_AW       = 4,
  parameter int MAX_BURST_LEN = 2**FIFO_AW
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [WB_AW-1:0]   wbm_adr_o,
  output logic [WB_DW-1:0]   wbm_dat_o,
  output logic [WB_DW/8-1:0] wbm_sel_o,
  output logic               wbm_we_o,
  output logic               wbm_cyc_o,
  output logic               wbm_stb_o,
  output logic [2:0]         wbm_cti_o,
  output logic [1:0]         wbm_bte_o,
  input  logic [WB_DW-1:0]   wbm_dat_i,
  input  logic               wbm_ack_i,
  input  logic               wbm_err_i,
  output logic [WB_DW-1:0]   stream_m_data_o,
  output logic               stream_m_valid_o,
  input  logic               stream_m_ready_i,
  output logic               stream_m_last_o,
  input  logic               enable,
  input  logic [WB_AW-1:0]   start_adr,
  input  logic [WB_AW-1:0]   buf_size,
  input  logic [WB_AW-1:0]   burst_size,
  output logic               busy,
  output logic               irq_o,
  output logic               err_o
);

  localparam logic [WB_AW-1:0] ADR_STEP = WB_AW'(WB_DW / 8);
  localparam logic [WB_AW-1:0] MAX_LEN  = WB_AW'(MAX_BURST_LEN);
  localparam logic [WB_AW-1:0] ONE      = WB_AW'(1);

  fetch_state_e     state_q, state_d;
  logic [WB_AW-1:0] adr_q, adr_d;
  logic [WB_AW-1:0] remaining_q, remaining_d;
  logic [WB_AW-1:0] burst_left_q, burst_left_d;
  logic             cyc_q, cyc_d;
  logic             busy_q, busy_d;
  logic             irq_q, irq_d;
  logic             err_q, err_d;

  logic [WB_AW-1:0] blen;
  logic [FIFO_AW:0] fifo_free;
  logic [WB_DW:0]   fifo_dout;
  logic             fifo_valid;
  logic             push;
  logic             push_last;

  always_comb begin
    blen = (burst_size == '0) ? ONE : burst_size;
    if (blen > MAX_LEN)     blen = MAX_LEN;
    if (blen > remaining_q) blen = remaining_q;
  end

  always_comb begin
    state_d      = state_q;
    adr_d        = adr_q;
    remaining_d  = remaining_q;
    burst_left_d = burst_left_q;
    cyc_d        = cyc_q;
    busy_d       = busy_q;
    irq_d        = 1'b0;
    err_d        = 1'b0;
    push         = 1'b0;
    push_last    = 1'b0;

    case (state_q)
      IDLE: begin
        if (enable) begin
          adr_d       = start_adr;
          remaining_d = buf_size;
          busy_d      = 1'b1;
          state_d     = (buf_size == '0) ? DONE : CHECK;
        end
      end

      CHECK: begin
        if (WB_AW'(fifo_free) >= blen) begin
          burst_left_d = blen;
          cyc_d        = 1'b1;
          state_d      = READ;
        end
      end

      READ: begin
        if (!cyc_q) begin
          // Idle gap between classic single-word cycles.
          cyc_d = 1'b1;
        end else if (wbm_err_i) begin
          cyc_d   = 1'b0;
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (wbm_ack_i) begin
          push         = 1'b1;
          push_last    = (remaining_q == ONE);
          adr_d        = adr_q + ADR_STEP;
          remaining_d  = remaining_q - ONE;
          burst_left_d = burst_left_q - ONE;
          if (burst_left_q == ONE) begin
            cyc_d = 1'b0;
            if (remaining_q == ONE) begin
              state_d = DONE;
            end else if (!enable) begin
              busy_d  = 1'b0;
              state_d = IDLE;
            end else begin
              state_d = CHECK;
            end
          end else begin
`ifndef WB_STREAM_FETCH_BURST_EN
            cyc_d = 1'b0;
`endif
          end
        end
      end

      DONE: begin
        irq_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      adr_q        <= '0;
      remaining_q  <= '0;
      burst_left_q <= '0;
      cyc_q        <= 1'b0;
      busy_q       <= 1'b0;
      irq_q        <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      adr_q        <= adr_d;
      remaining_q  <= remaining_d;
      burst_left_q <= burst_left_d;
      cyc_q        <= cyc_d;
      busy_q       <= busy_d;
      irq_q        <= irq_d;
      err_q        <= err_d;
    end
  end

  wb_stream_fetch_fifo #(
    .DW (WB_DW + 1),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_data_i ({push_last, wbm_dat_i}),
    .pop_i       (stream_m_ready_i),
    .pop_data_o  (fifo_dout),
    .valid_o     (fifo_valid),
    .free_o      (fifo_free)
  );

`ifdef WB_STREAM_FETCH_BURST_EN
  assign wbm_cti_o = !cyc_q ? CTI_CLASSIC : ((burst_left_q == ONE) ? CTI_EOB : CTI_INC);
`else
  assign wbm_cti_o = CTI_CLASSIC;
`endif

  assign wbm_adr_o        = adr_q;
  assign wbm_dat_o        = '0;
  assign wbm_sel_o        = '1;
  assign wbm_we_o         = 1'b0;
  assign wbm_cyc_o        = cyc_q;
  assign wbm_stb_o        = cyc_q;
  assign wbm_bte_o        = BTE_LINEAR;
  assign stream_m_data_o  = fifo_dout[WB_DW-1:0];
  assign stream_m_valid_o = fifo_valid;
  assign stream_m_last_o  = fifo_valid & fifo_dout[WB_DW];
  assign busy             = busy_q;
  assign irq_o            = irq_q;
  assign err_o            = err_q;

endmodule

// File: tb/tb_wb_stream_fetch.sv
// Self-checking bench for wb_stream_fetch: randomized slave/sink against a transfer-level model.
module tb_wb_stream_fetch;

  localparam int MAXB = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
  logic [3:0]  wbm_sel_o;
  logic        wbm_we_o, wbm_cyc_o, wbm_stb_o;
  logic [2:0]  wbm_cti_o;
  logic [1:0]  wbm_bte_o;
  logic        wbm_ack_i, wbm_err_i;
  logic [31:0] stream_m_data_o;
  logic        stream_m_valid_o, stream_m_ready_i, stream_m_last_o;
  logic        enable;
  logic [31:0] start_adr, buf_size, burst_size;
  logic        busy, irq_o, err_o;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_count = 0;
  int irq_cnt, err_cnt, beat_num, err_at;
  int ready_mode;
  bit wait_en;

  logic [31:0] beat_adr_q[$];
  logic [2:0]  beat_cti_q[$];
  int          beat_cyc_q[$];
  logic [32:0] word_q[$];

  bit          prev_stall = 1'b0;
  logic [32:0] prev_word;

  always #5 clk = ~clk;

  wb_stream_fetch dut (
    .clk(clk), .rst_n(rst_n),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
    .wbm_we_o(wbm_we_o), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
    .wbm_cti_o(wbm_cti_o), .wbm_bte_o(wbm_bte_o), .wbm_dat_i(wbm_dat_i),
    .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i),
    .stream_m_data_o(stream_m_data_o), .stream_m_valid_o(stream_m_valid_o),
    .stream_m_ready_i(stream_m_ready_i), .stream_m_last_o(stream_m_last_o),
    .enable(enable), .start_adr(start_adr), .buf_size(buf_size),
    .burst_size(burst_size), .busy(busy), .irq_o(irq_o), .err_o(err_o)
  );

  function automatic logic [31:0] slave_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC3C3_0000;
  endfunction

  // Slave and sink: decide ack/err/ready on the falling edge, record what the next rising edge consumes.
  initial begin
    wbm_ack_i = 1'b0; wbm_err_i = 1'b0; wbm_dat_i = '0; stream_m_ready_i = 1'b0;
    forever begin
      @(negedge clk);
      cyc_count++;
      if (irq_o) irq_cnt++;
      if (err_o) err_cnt++;
      if (prev_stall && stream_m_valid_o) begin
        n_checks++;
        if ({stream_m_last_o, stream_m_data_o} !== prev_word) begin
          n_fail++;
          $display("FAIL stall_hold: got %h required %h", {stream_m_last_o, stream_m_data_o}, prev_word);
        end
      end
      wbm_ack_i = 1'b0;
      wbm_err_i = 1'b0;
      wbm_dat_i = $urandom;
      if (wbm_cyc_o && wbm_stb_o && (!wait_en || $urandom_range(0, 2) != 0)) begin
        beat_num++;
        if (beat_num == err_at) begin
          wbm_err_i = 1'b1;
        end else begin
          wbm_ack_i = 1'b1;
          wbm_dat_i = slave_word(wbm_adr_o);
          beat_adr_q.push_back(wbm_adr_o);
          beat_cti_q.push_back(wbm_cti_o);
          beat_cyc_q.push_back(cyc_count);
        end
      end
      case (ready_mode)
        0:       stream_m_ready_i = 1'b0;
        1:       stream_m_ready_i = 1'b1;
        default: stream_m_ready_i = 1'($urandom_range(0, 1));
      endcase
      if (stream_m_valid_o && stream_m_ready_i)
        word_q.push_back({stream_m_last_o, stream_m_data_o});
      prev_stall = stream_m_valid_o && !stream_m_ready_i;
      prev_word  = {stream_m_last_o, stream_m_data_o};
    end
  end

  task automatic clear_logs();
    beat_adr_q.delete(); beat_cti_q.delete(); beat_cyc_q.delete(); word_q.delete();
    irq_cnt = 0; err_cnt = 0; beat_num = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (wbm_cyc_o !== 1'b0) begin n_fail++; $display("FAIL rst_cyc: got %b required 0", wbm_cyc_o); end
    n_checks++; if (wbm_stb_o !== 1'b0) begin n_fail++; $display("FAIL rst_stb: got %b required 0", wbm_stb_o); end
    n_checks++; if (wbm_adr_o !== 32'h0) begin n_fail++; $display("FAIL rst_adr: got %h required 0", wbm_adr_o); end
    n_checks++; if (wbm_cti_o !== 3'b000) begin n_fail++; $display("FAIL rst_cti: got %b required 000", wbm_cti_o); end
    n_checks++; if (stream_m_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b required 0", stream_m_valid_o); end
    n_checks++; if (stream_m_last_o !== 1'b0) begin n_fail++; $display("FAIL rst_last: got %b required 0", stream_m_last_o); end
    n_checks++; if ({busy, irq_o, err_o} !== 3'b000) begin n_fail++; $display("FAIL rst_status: got %b required 000", {busy, irq_o, err_o}); end
    n_checks++; if ({wbm_we_o, wbm_bte_o, wbm_dat_o} !== 35'h0) begin n_fail++; $display("FAIL rst_ties: got %h required 0", {wbm_we_o, wbm_bte_o, wbm_dat_o}); end
    n_checks++; if (wbm_sel_o !== 4'hF) begin n_fail++; $display("FAIL sel_ones: got %h required f", wbm_sel_o); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Full transfer to completion, compared beat by beat and word by word against the buffer model.
  task automatic run_xfer(input logic [31:0] sa, input int size, input int bs, input string name);
    logic [2:0]  exp_cti[$];
    bit          exp_first[$];
    int          rem, chunk, bl, nb, nw;
    bit          done;
    clear_logs();
    @(negedge clk);
    start_adr = sa; buf_size = 32'(size); burst_size = 32'(bs); enable = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 20000 && !done; i++) begin
      @(negedge clk);
      if (irq_o) done = 1'b1;
    end
    enable = 1'b0;
    n_checks++; if (!done) begin n_fail++; $display("FAIL %s_timeout: got no irq required irq", name); end
    for (int i = 0; i < 2000 && stream_m_valid_o; i++) @(negedge clk);
    repeat (3) @(negedge clk);

    bl = (bs == 0) ? 1 : bs;
    if (bl > MAXB) bl = MAXB;
    rem = size;
    while (rem > 0) begin
      chunk = (bl < rem) ? bl : rem;
      for (int j = 0; j < chunk; j++) begin
`ifdef WB_STREAM_FETCH_BURST_EN
        exp_cti.push_back((j == chunk - 1) ? 3'b111 : 3'b010);
`else
        exp_cti.push_back(3'b000);
`endif
        exp_first.push_back(j == 0);
      end
      rem -= chunk;
    end

    nb = beat_adr_q.size();
    n_checks++; if (nb != size) begin n_fail++; $display("FAIL %s_beats: got %0d required %0d", name, nb, size); end
    if (nb > size) nb = size;
    for (int i = 0; i < nb; i++) begin
      n_checks++;
      if (beat_adr_q[i] !== sa + 32'(4 * i)) begin
        n_fail++; $display("FAIL %s_adr[%0d]: got %h required %h", name, i, beat_adr_q[i], sa + 32'(4 * i));
      end
      n_checks++;
      if (beat_cti_q[i] !== exp_cti[i]) begin
        n_fail++; $display("FAIL %s_cti[%0d]: got %b required %b", name, i, beat_cti_q[i], exp_cti[i]);
      end
      if (i > 0) begin
`ifdef WB_STREAM_FETCH_BURST_EN
        if (!exp_first[i] && !wait_en) begin
          n_checks++;
          if (beat_cyc_q[i] - beat_cyc_q[i-1] != 1) begin
            n_fail++; $display("FAIL %s_burst_gap[%0d]: got %0d required 1", name, i, beat_cyc_q[i] - beat_cyc_q[i-1]);
          end
        end
`else
        n_checks++;
        if (beat_cyc_q[i] - beat_cyc_q[i-1] < 2) begin
          n_fail++; $display("FAIL %s_classic_gap[%0d]: got %0d required >=2", name, i, beat_cyc_q[i] - beat_cyc_q[i-1]);
        end
`endif
      end
    end

    nw = word_q.size();
    n_checks++; if (nw != size) begin n_fail++; $display("FAIL %s_words: got %0d required %0d", name, nw, size); end
    if (nw > size) nw = size;
    for (int i = 0; i < nw; i++) begin
      n_checks++;
      if (word_q[i] !== {(i == size - 1), slave_word(sa + 32'(4 * i))}) begin
        n_fail++; $display("FAIL %s_word[%0d]: got %h required %h", name, i, word_q[i], {(i == size - 1), slave_word(sa + 32'(4 * i))});
      end
    end
    n_checks++; if (irq_cnt != 1) begin n_fail++; $display("FAIL %s_irq_count: got %0d required 1", name, irq_cnt); end
    n_checks++; if (err_cnt != 0) begin n_fail++; $display("FAIL %s_err_count: got %0d required 0", name, err_cnt); end
    n_checks++; if ({busy, wbm_cyc_o} !== 2'b00) begin n_fail++; $display("FAIL %s_idle: got busy,cyc=%b required 00", name, {busy, wbm_cyc_o}); end
  endtask

  task automatic test_basic();
    wait_en = 1'b0; ready_mode = 1;
    run_xfer(32'h0000_1000, 8, 4, "basic");
    run_xfer(32'h0000_1100, 5, 4, "tail");
    run_xfer(32'h0000_1200, 3, 4, "three");
    run_xfer(32'h0000_1300, 20, 0, "bs_zero");
    run_xfer(32'h0000_1400, 20, 40, "bs_clamp");
  endtask

  task automatic test_random();
    for (int k = 0; k < 10; k++) begin
      logic [31:0] sa;
      sa = {$urandom, 2'b00};
      sa = sa & 32'hFFFF_FFFC;
      if (k == 0) sa = 32'hFFFF_FFF0;
      wait_en = 1'($urandom_range(0, 1));
      ready_mode = 2;
      run_xfer(sa, $urandom_range(1, 40), $urandom_range(0, 20), (k == 0) ? "wrap" : "rand");
    end
  endtask

  task automatic test_zero_len();
    wait_en = 1'b0; ready_mode = 1;
    clear_logs();
    @(negedge clk);
    buf_size = 32'd0; burst_size = 32'd4; start_adr = 32'h0000_2000; enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    n_checks++; if ({irq_o, busy} !== 2'b01) begin n_fail++; $display("FAIL zero_c1: got irq,busy=%b required 01", {irq_o, busy}); end
    @(negedge clk);
    n_checks++; if ({irq_o, busy} !== 2'b10) begin n_fail++; $display("FAIL zero_c2: got irq,busy=%b required 10", {irq_o, busy}); end
    @(negedge clk);
    n_checks++; if (irq_o !== 1'b0) begin n_fail++; $display("FAIL zero_c3: got irq=%b required 0", irq_o); end
    repeat (5) @(negedge clk);
    n_checks++; if (beat_adr_q.size() != 0) begin n_fail++; $display("FAIL zero_beats: got %0d required 0", beat_adr_q.size()); end
    n_checks++; if (irq_cnt != 1) begin n_fail++; $display("FAIL zero_irq_count: got %0d required 1", irq_cnt); end
  endtask

  task automatic test_backpressure();
    bit done;
    wait_en = 1'b0; ready_mode = 0;
    clear_logs();
    @(negedge clk);
    start_adr = 32'h0000_3000; buf_size = 32'd40; burst_size = 32'd4; enable = 1'b1;
    repeat (200) @(negedge clk);
    n_checks++; if (beat_adr_q.size() != MAXB) begin n_fail++; $display("FAIL bp_fill: got %0d required %0d", beat_adr_q.size(), MAXB); end
    n_checks++; if ({busy, wbm_cyc_o, stream_m_valid_o} !== 3'b101) begin n_fail++; $display("FAIL bp_stall: got busy,cyc,valid=%b required 101", {busy, wbm_cyc_o, stream_m_valid_o}); end
    n_checks++; if (stream_m_data_o !== slave_word(32'h0000_3000)) begin n_fail++; $display("FAIL bp_head: got %h required %h", stream_m_data_o, slave_word(32'h0000_3000)); end
    ready_mode = 1;
    done = 1'b0;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(negedge clk);
      if (irq_o) done = 1'b1;
    end
    enable = 1'b0;
    for (int i = 0; i < 100 && stream_m_valid_o; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    n_checks++; if (!done) begin n_fail++; $display("FAIL bp_timeout: got no irq required irq"); end
    n_checks++; if (word_q.size() != 40) begin n_fail++; $display("FAIL bp_words: got %0d required 40", word_q.size()); end
    for (int i = 0; i < word_q.size() && i < 40; i++) begin
      n_checks++;
      if (word_q[i] !== {(i == 39), slave_word(32'h0000_3000 + 32'(4 * i))}) begin
        n_fail++; $display("FAIL bp_word[%0d]: got %h required %h", i, word_q[i], {(i == 39), slave_word(32'h0000_3000 + 32'(4 * i))});
      end
    end
    n_checks++; if (irq_cnt != 1) begin n_fail++; $display("FAIL bp_irq_count: got %0d required 1", irq_cnt); end
  endtask

  task automatic test_error();
    bit seen;
    wait_en = 1'b0; ready_mode = 0;
    clear_logs();
    err_at = 2;
    @(negedge clk);
    start_adr = 32'h0000_4000; buf_size = 32'd8; burst_size = 32'd4; enable = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (err_o) seen = 1'b1;
    end
    enable = 1'b0;
    err_at = 0;
    n_checks++; if (!seen) begin n_fail++; $display("FAIL err_timeout: got no err_o required err_o"); end
    n_checks++; if ({wbm_cyc_o, busy} !== 2'b00) begin n_fail++; $display("FAIL err_stop: got cyc,busy=%b required 00", {wbm_cyc_o, busy}); end
    repeat (4) @(negedge clk);
    n_checks++; if (err_cnt != 1) begin n_fail++; $display("FAIL err_pulse: got %0d required 1", err_cnt); end
    n_checks++; if (irq_cnt != 0) begin n_fail++; $display("FAIL err_irq: got %0d required 0", irq_cnt); end
    n_checks++; if (beat_adr_q.size() != 1) begin n_fail++; $display("FAIL err_beats: got %0d required 1", beat_adr_q.size()); end
    n_checks++; if ({stream_m_valid_o, stream_m_last_o, stream_m_data_o} !== {2'b10, slave_word(32'h0000_4000)}) begin
      n_fail++; $display("FAIL err_fifo_head: got %h required %h", {stream_m_valid_o, stream_m_last_o, stream_m_data_o}, {2'b10, slave_word(32'h0000_4000)});
    end
    ready_mode = 1;
    repeat (6) @(negedge clk);
    n_checks++; if (word_q.size() != 1) begin n_fail++; $display("FAIL err_fifo_count: got %0d required 1", word_q.size()); end
    n_checks++; if (stream_m_valid_o !== 1'b0) begin n_fail++; $display("FAIL err_fifo_empty: got %b required 0", stream_m_valid_o); end
  endtask

  task automatic test_enable_drop();
    bit seen;
    wait_en = 1'b1; ready_mode = 1;
    clear_logs();
    @(negedge clk);
    start_adr = 32'h0000_5000; buf_size = 32'd8; burst_size = 32'd4; enable = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (wbm_cyc_o) seen = 1'b1;
    end
    enable = 1'b0;
    repeat (100) @(negedge clk);
    n_checks++; if (!seen) begin n_fail++; $display("FAIL drop_timeout: got no cyc required cyc"); end
    n_checks++; if (beat_adr_q.size() != 4) begin n_fail++; $display("FAIL drop_beats: got %0d required 4", beat_adr_q.size()); end
    n_checks++; if (word_q.size() != 4) begin n_fail++; $display("FAIL drop_words: got %0d required 4", word_q.size()); end
    for (int i = 0; i < word_q.size() && i < 4; i++) begin
      n_checks++;
      if (word_q[i] !== {1'b0, slave_word(32'h0000_5000 + 32'(4 * i))}) begin
        n_fail++; $display("FAIL drop_word[%0d]: got %h required %h", i, word_q[i], {1'b0, slave_word(32'h0000_5000 + 32'(4 * i))});
      end
    end
    n_checks++; if ({busy, wbm_cyc_o} !== 2'b00) begin n_fail++; $display("FAIL drop_idle: got busy,cyc=%b required 00", {busy, wbm_cyc_o}); end
    n_checks++; if (irq_cnt != 0) begin n_fail++; $display("FAIL drop_irq: got %0d required 0", irq_cnt); end
  endtask

  task automatic test_reset_mid_burst();
    bit seen;
    wait_en = 1'b1; ready_mode = 0;
    clear_logs();
    @(negedge clk);
    start_adr = 32'h0000_6000; buf_size = 32'd16; burst_size = 32'd8; enable = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (beat_adr_q.size() >= 2 && wbm_cyc_o) seen = 1'b1;
    end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL rmb_timeout: got no burst required burst"); end
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if ({wbm_cyc_o, wbm_stb_o, stream_m_valid_o} !== 3'b000) begin n_fail++; $display("FAIL rmb_drop: got cyc,stb,valid=%b required 000", {wbm_cyc_o, wbm_stb_o, stream_m_valid_o}); end
    n_checks++; if ({busy, wbm_cti_o, wbm_adr_o} !== 36'h0) begin n_fail++; $display("FAIL rmb_regs: got %h required 0", {busy, wbm_cti_o, wbm_adr_o}); end
    enable = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++; if ({wbm_cyc_o, stream_m_valid_o, busy} !== 3'b000) begin n_fail++; $display("FAIL rmb_after: got cyc,valid,busy=%b required 000", {wbm_cyc_o, stream_m_valid_o, busy}); end
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; start_adr = '0; buf_size = '0; burst_size = '0;
    wait_en = 1'b0; ready_mode = 1; err_at = 0; irq_cnt = 0; err_cnt = 0; beat_num = 0;
    test_reset();
    test_basic();
    test_zero_len();
    test_backpressure();
    test_error();
    test_enable_drop();
    test_reset_mid_burst();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
